// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bit counter must hold 0..width so the last-bit index is always representable.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// Full-adder bit slice from two half adders plus an OR for carry.
// Combinational, zero latency, no flow control.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    ha u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    ha u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;

endmodule

// File: rtl/ha.sv
// Half-adder cell: combinational, zero latency, no flow control.
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first; done pulses WIDTH+1 cycles after start is accepted.
// start is only sampled while ready=1; requests during SHIFT/DONE are dropped, not queued.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             s_bit;
    logic             c_bit;
    logic             last_bit;

    fa_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (s_bit),
        .cout (c_bit)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the first sum bit.
    assign res_nxt  = WIDTH'({s_bit, res_sh} >> 1);
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                a_sh   <= a_in;
                b_sh   <= b_in;
                res_sh <= '0;
                carry  <= 1'b0;
                cnt    <= '0;
            end else if (state == S_SHIFT) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res_sh <= res_nxt;
                carry  <= c_bit;
                if (last_bit) begin
                    sum_out   <= res_nxt;
                    carry_out <= c_bit;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
